// File: rtl/cache_pkg.sv
// cache_pkg: op encodings, FSM states and word width shared by the cache storage block
package cache_pkg;
    localparam int WORD_BITS = 32;
    localparam logic [1:0] CACHE_OP_LOOKUP = 2'd0;
    localparam logic [1:0] CACHE_OP_WRITE  = 2'd1;
    localparam logic [1:0] CACHE_OP_FILL   = 2'd2;
    typedef enum logic {ST_IDLE, ST_FLUSH} cache_state_t;
endpackage

// File: rtl/cache_plru.sv
// cache_plru: tree-PLRU next-state and victim for one set (heap order, node 0 is the root)
module cache_plru #(
    parameter int NUM_WAYS = 4,
    parameter int WAY_BITS = $clog2(NUM_WAYS)
) (
    input  logic [NUM_WAYS-2:0] tree,
    input  logic [WAY_BITS-1:0] touch,
    output logic [NUM_WAYS-2:0] tree_nxt,
    output logic [WAY_BITS-1:0] victim
);
    localparam logic [NUM_WAYS-2:0] ONE = 1;
    // a node bit of 1 means the victim lies in the right subtree
    always_comb begin
        int n;
        n = 0;
        tree_nxt = tree;
        for (int l = 0; l < WAY_BITS; l++) begin
            tree_nxt = touch[WAY_BITS-1-l] ? tree_nxt & ~(ONE << n) : tree_nxt | (ONE << n);
            n = 2 * n + 1 + int'(touch[WAY_BITS-1-l]);
        end
    end
    always_comb begin
        int v;
        v = 0;
        victim = '0;
        for (int l = 0; l < WAY_BITS; l++) begin
            victim[WAY_BITS-1-l] = |(tree & (ONE << v));
            v = 2 * v + 1 + int'(victim[WAY_BITS-1-l]);
        end
    end
endmodule

// File: rtl/cache_nway_array.sv
// cache_nway_array: N-way set-associative storage with valid/dirty, tree-PLRU,
// lookup/write/fill behind one valid/ready port and a whole-cache invalidate sweep
module cache_nway_array
    import cache_pkg::*;
#(
    parameter int NUM_WAYS   = 4,
    parameter int INDEX_BITS = 5,
    parameter int TAG_BITS   = 23,
    parameter int WORD_NUM   = 4,
    parameter int WAY_BITS   = $clog2(NUM_WAYS),
    localparam int NUM_SETS  = 2**INDEX_BITS,
    localparam int LINE_BITS = WORD_BITS * WORD_NUM
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [1:0]            req_op,
    input  logic [INDEX_BITS-1:0] req_index,
    input  logic [TAG_BITS-1:0]   req_tag,
    input  logic [LINE_BITS-1:0]  req_wdata,
    input  logic [WORD_NUM-1:0]   req_word_en,
    input  logic [3:0]            req_byte_en,
    input  logic                  req_dirty,
    output logic                  rsp_valid,
    output logic                  rsp_hit,
    output logic [WAY_BITS-1:0]   rsp_way,
    output logic [LINE_BITS-1:0]  rsp_rdata,
    output logic                  rsp_victim_valid,
    output logic                  rsp_victim_dirty,
    output logic [TAG_BITS-1:0]   rsp_victim_tag,
    input  logic                  flush_start,
    output logic                  flush_busy,
    output logic                  flush_done
);
    cache_state_t          state;
    logic [INDEX_BITS-1:0] flush_cnt;
    logic [LINE_BITS-1:0]  data_q  [NUM_WAYS][NUM_SETS];
    logic [TAG_BITS-1:0]   tag_q   [NUM_WAYS][NUM_SETS];
    logic [NUM_WAYS-1:0]   valid_q [NUM_SETS];
    logic [NUM_WAYS-1:0]   dirty_q [NUM_SETS];
    logic [NUM_WAYS-2:0]   plru_q  [NUM_SETS];

    logic                  accept, is_write, is_fill, hit;
    logic [NUM_WAYS-1:0]   set_valid, hit_vec;
    logic [WAY_BITS-1:0]   hit_way, inv_way, plru_victim, fill_way, sel_way;
    logic [NUM_WAYS-2:0]   plru_nxt;
    logic [LINE_BITS-1:0]  rdata, wmask, wline;

    assign req_ready  = (state == ST_IDLE) && !flush_start;
    assign accept     = req_valid && req_ready;
    assign is_write   = req_op == CACHE_OP_WRITE;
    assign is_fill    = req_op == CACHE_OP_FILL;
    assign flush_busy = state == ST_FLUSH;
    assign set_valid  = valid_q[req_index];

    // descending scan so the lowest matching / lowest invalid way wins
    always_comb begin
        hit_vec = '0;
        hit_way = '0;
        inv_way = '0;
        for (int w = NUM_WAYS - 1; w >= 0; w--) begin
            hit_vec[w] = set_valid[w] && tag_q[w][req_index] == req_tag;
            hit_way = hit_vec[w] ? WAY_BITS'(w) : hit_way;
            inv_way = set_valid[w] ? inv_way : WAY_BITS'(w);
        end
    end

    assign hit      = |hit_vec;
    assign fill_way = &set_valid ? plru_victim : inv_way;
    assign sel_way  = is_fill ? fill_way : hit_way;
    assign rdata    = data_q[sel_way][req_index];

    always_comb begin
        wmask = '0;
        for (int w = 0; w < WORD_NUM; w++)
            for (int b = 0; b < 4; b++)
                wmask[w*WORD_BITS + b*8 +: 8] = {8{req_word_en[w] & req_byte_en[b]}};
    end
    assign wline = (rdata & ~wmask) | (req_wdata & wmask);

    cache_plru #(.NUM_WAYS(NUM_WAYS), .WAY_BITS(WAY_BITS)) u_plru (
        .tree     (plru_q[req_index]),
        .touch    (sel_way),
        .tree_nxt (plru_nxt),
        .victim   (plru_victim)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state            <= ST_IDLE;
            flush_cnt        <= '0;
            flush_done       <= 1'b0;
            rsp_valid        <= 1'b0;
            rsp_hit          <= 1'b0;
            rsp_way          <= '0;
            rsp_rdata        <= '0;
            rsp_victim_valid <= 1'b0;
            rsp_victim_dirty <= 1'b0;
            rsp_victim_tag   <= '0;
            for (int s = 0; s < NUM_SETS; s++) begin
                valid_q[s] <= '0;
                dirty_q[s] <= '0;
                plru_q[s]  <= '0;
            end
        end else begin
            flush_done <= 1'b0;
            rsp_valid  <= accept;
            if (accept) begin
                rsp_hit          <= hit && !is_fill;
                rsp_way          <= sel_way;
                rsp_rdata        <= rdata;
                rsp_victim_valid <= is_fill && set_valid[fill_way];
                rsp_victim_dirty <= is_fill && dirty_q[req_index][fill_way];
                rsp_victim_tag   <= is_fill ? tag_q[fill_way][req_index] : '0;
                if (is_fill || hit)
                    plru_q[req_index] <= plru_nxt;
                if (is_fill) begin
                    valid_q[req_index][fill_way] <= 1'b1;
                    dirty_q[req_index][fill_way] <= req_dirty;
                end else if (is_write && hit)
                    dirty_q[req_index][hit_way] <= 1'b1;
            end
            if (state == ST_FLUSH) begin
                valid_q[flush_cnt] <= '0;
                dirty_q[flush_cnt] <= '0;
                plru_q[flush_cnt]  <= '0;
                flush_cnt          <= flush_cnt + 1'b1;
                if (flush_cnt == INDEX_BITS'(NUM_SETS - 1)) begin
                    state      <= ST_IDLE;
                    flush_done <= 1'b1;
                end
            end else if (flush_start) begin
                state     <= ST_FLUSH;
                flush_cnt <= '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept && is_fill) begin
            data_q[fill_way][req_index] <= req_wdata;
            tag_q[fill_way][req_index]  <= req_tag;
        end else if (accept && is_write && hit)
            data_q[hit_way][req_index] <= wline;
    end
endmodule

// File: doc/cache_nway_array.md
# cache_nway_array

Parametrised N-way set-associative cache storage block: per-way data/tag arrays plus per-line valid and dirty bits, tree-PLRU replacement state, hit detection and a whole-cache invalidate sweep. It is the next-generation storage core beneath the cache controller FSM and generalises the fixed 2-way tag/data pair to any power-of-two way count. It adds lookup, write-hit, fill-with-victim-report and flush operations behind a single valid/ready request port.

## Interface
- NUM_WAYS, 4, ways per set; power of two, at least 2.
- INDEX_BITS, 5, set index width; NUM_SETS = 2**INDEX_BITS.
- TAG_BITS, 23, tag width.
- WORD_NUM, 4, 32-bit words per line; LINE_BITS = 32*WORD_NUM.
- WAY_BITS, $clog2(NUM_WAYS), way-number width.
- clk  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted when both req_valid and req_ready are high at a clock edge.
- req_op  in  2  operation: LOOKUP=0, WRITE=1, FILL=2; 3 is reserved and treated as LOOKUP.
- req_index  in  INDEX_BITS  set index.
- req_tag  in  TAG_BITS  compare/fill tag.
- req_wdata  in  LINE_BITS  write/fill data.
- req_word_en  in  WORD_NUM  WRITE word enables.
- req_byte_en  in  4  WRITE byte enables, applied inside every enabled word.
- req_dirty  in  1  dirty value installed by FILL.
- rsp_valid  out  1  one-cycle response pulse.
- rsp_hit  out  1  tag matched a valid way.
- rsp_way  out  WAY_BITS  hit way; on FILL, the way filled.
- rsp_rdata  out  LINE_BITS  line read at accept, before any write in that cycle.
- rsp_victim_valid / rsp_victim_dirty  out  1 each  FILL only: prior state of the replaced line.
- rsp_victim_tag  out  TAG_BITS  FILL only: prior tag of the replaced line.
- flush_start  in  1  start an invalidate sweep.
- flush_busy  out  1  sweep in progress.
- flush_done  out  1  one-cycle pulse when the sweep completes.

## Operation
- The FSM has two states, IDLE and FLUSH. req_ready = (state==IDLE) & !flush_start.
- LOOKUP
  - Compares req_tag against all valid ways of the indexed set.
  - On a hit, updates PLRU so the hit way becomes most-recent.
  - On a miss, changes no state.
- WRITE
  - On a hit, writes the selected bytes of the selected words of the hit way, sets its dirty bit and updates PLRU.
  - On a miss, performs no write and changes no state; rsp_hit=0.
- FILL
  - Victim selection: the lowest-numbered invalid way; if every way is valid, the PLRU victim.
  - Writes the full line and tag into the victim, sets valid=1 and dirty=req_dirty, and updates PLRU.
  - The response carries the victim's old tag, valid, dirty and data so the controller can write back.
  - FILL ignores req_word_en and req_byte_en.
  - FILL performs no hit check, so rsp_hit=0.
- PLRU is a per-set tree of NUM_WAYS-1 bits.
  - Update: each node on the path to the touched way points away from it.
  - Victim: follow the node bits from the root.
- More than one matching valid way is a controller error; the lowest such way wins.
- FLUSH
  - flush_start in IDLE enters FLUSH with the sweep counter at 0.
  - Each cycle, clears valid, dirty and PLRU of set[counter], then increments the counter.
  - After set NUM_SETS-1 is cleared, returns to IDLE and pulses flush_done.
  - Data and tag arrays are not cleared.
  - flush_start while in FLUSH is ignored.
  - flush_start together with req_valid: the flush wins and the request is not accepted.

## Timing
- Reset values:
  - Outputs: rsp_* = 0, flush_busy = 0, flush_done = 0.
  - req_ready = 1 while flush_start is low.
  - State: IDLE; all valid, dirty and PLRU bits 0; data and tag arrays unreset.
- Latency:
  - The response is registered: rsp_valid is high exactly one cycle after acceptance.
  - rsp_* fields hold their value until the next response.
- Throughput: one request per cycle.
- A back-to-back request to the same set sees the previous cycle's write, because the write commits at the accept edge.
- A flush takes NUM_SETS cycles.
  - flush_busy is high from the cycle after flush_start through the last sweep cycle.
  - flush_done pulses in the first IDLE cycle after the sweep.
- Reset asserted mid-sweep or mid-request returns the block to IDLE immediately, with valid bits cleared and any pending response dropped.

## Structure
- Package cache_pkg:
  - op encodings CACHE_OP_LOOKUP, CACHE_OP_WRITE, CACHE_OP_FILL;
  - FSM state enum (ST_IDLE, ST_FLUSH);
  - the WORD_BITS=32 constant.
- Sub-module cache_plru: combinational, parameter NUM_WAYS.
  - Inputs: tree bits and the touched way.
  - Outputs: next tree bits and the victim way.
- Instantiated once, operating on the indexed set.

## Test plan
- Reset, then LOOKUP index 3, tag 0x1234 -> rsp_hit=0 one cycle later.
- FILL index 3, tag 0x1234, data 0xA..., dirty=0, then LOOKUP -> FILL reports rsp_way=0 and rsp_victim_valid=0; the LOOKUP returns rsp_hit=1, rsp_way=0 and the filled data.
- WRITE hit with word_en=0b0010, byte_en=0b0001, data 0xFF -> only byte 4 changes; a following FILL that evicts this line reports rsp_victim_dirty=1.
- NUM_WAYS=4: fill ways 0-3 of one set, LOOKUP-hit way 0, FILL again -> victim is way 2 per the PLRU tree; the response returns the old tag and data.
- flush_start with INDEX_BITS=5 -> flush_busy for 32 cycles and req_ready=0, then a flush_done pulse; every previous hit now misses.
- Assert rst_n low at flush cycle 10 -> IDLE and req_ready=1 after release; all lookups miss.
